// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: transfer sizes, FSM states and
// the exception-vector byte addresses that are reloaded on reset.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ADDR_VEC_OVF = 253;
    localparam int ADDR_VEC_OPC = 254;
    localparam int ADDR_VEC_DIV = 255;

    // Number of bytes touched by a transfer; the reserved size errors out anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between an address-path master and the memory responder.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the master holds all req_* fields stable while req_valid is high and not yet
// accepted. rsp_valid is a one-cycle pulse with no back-pressure; rsp_rdata and
// rsp_err are meaningful only while rsp_valid is high.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Big-endian lane steering: bit 0 of the enable/byte vectors is offset A,
// carried in [31:24]; offset A+3 is carried in [7:0].
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [31:0] i_rd_bytes,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wr_bytes
);

    always_comb begin
        o_rdata    = 32'h0;
        o_we       = 4'b0000;
        o_wr_bytes = 32'h0;
        case (i_size)
            SZ_BYTE: begin
                o_rdata           = {24'h0, i_rd_bytes[31:24]};
                o_we              = 4'b0001;
                o_wr_bytes[31:24] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_rdata           = {16'h0, i_rd_bytes[31:16]};
                o_we              = 4'b0011;
                o_wr_bytes[31:16] = i_wdata[15:0];
            end
            SZ_WORD: begin
                o_rdata    = i_rd_bytes;
                o_we       = 4'b1111;
                o_wr_bytes = i_wdata;
            end
            default: begin
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, big-endian byte memory serving the CPU address path.
// One request in flight; the response pulse arrives LATENCY cycles after accept.
module mem_responder
    import mem_pkg::*;
#(
    parameter int         DEPTH_BYTES = 256,
    parameter int         LATENCY     = 2,
    parameter logic [7:0] VEC_OVF     = 8'd0,
    parameter logic [7:0] VEC_OPC     = 8'd0,
    parameter logic [7:0] VEC_DIV     = 8'd0
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output logic [1:0]       o_state
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    // Counter value in the last BUSY cycle, so that RESP lands in cycle LATENCY.
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic [31:0] w_raddr [4];
    logic [31:0] w_rd_bytes;
    logic [32:0] w_last_addr;
    logic        w_err;
    logic [31:0] w_lane_rdata;
    logic [3:0]  w_we;
    logic [31:0] w_wr_bytes;
    logic [31:0] w_rsp_rdata;
    logic        w_in_resp;

    assign w_in_resp = (r_state == ST_RESP);

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_last_addr = {1'b0, r_addr} + 33'(size_bytes(r_size)) - 33'd1;

    always_comb begin
        w_err = 1'b0;
        if (r_size == SZ_RSVD) begin
            w_err = 1'b1;
        end
        if ((r_size == SZ_HALF) && r_addr[0]) begin
            w_err = 1'b1;
        end
        if ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
        if (w_last_addr >= 33'(DEPTH_BYTES)) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_rd_bytes = 32'h0;
        for (int k = 0; k < 4; k++) begin
            w_raddr[k] = r_addr + 32'(k);
            if (w_raddr[k] < 32'(DEPTH_BYTES)) begin
                w_rd_bytes[31 - 8*k -: 8] = r_mem[w_raddr[k][IDX_W-1:0]];
            end
        end
    end

    mem_byte_lane u_lane (
        .i_size     (r_size),
        .i_rd_bytes (w_rd_bytes),
        .i_wdata    (r_wdata),
        .o_rdata    (w_lane_rdata),
        .o_we       (w_we),
        .o_wr_bytes (w_wr_bytes)
    );

    assign w_rsp_rdata = (w_err || r_write) ? 32'h0 : w_lane_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_size  <= bus.req_size;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= 4'd1;
                        r_state <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= w_rsp_rdata;
                    r_err   <= w_err;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Vector bytes are the only storage touched by reset; a reset edge also
    // suppresses the commit of any store in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (DEPTH_BYTES > ADDR_VEC_DIV) begin
                r_mem[IDX_W'(ADDR_VEC_OVF)] <= VEC_OVF;
                r_mem[IDX_W'(ADDR_VEC_OPC)] <= VEC_OPC;
                r_mem[IDX_W'(ADDR_VEC_DIV)] <= VEC_DIV;
            end
        end else if (w_in_resp && r_write && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_we[k]) begin
                    r_mem[w_raddr[k][IDX_W-1:0]] <= w_wr_bytes[31 - 8*k -: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = w_in_resp;
    assign bus.rsp_rdata = w_in_resp ? w_rsp_rdata : r_rdata;
    assign bus.rsp_err   = w_in_resp ? w_err : r_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

    localparam int         LAT   = 2;
    localparam int         DEPTH = 256;
    localparam logic [7:0] V_OVF = 8'h20;
    localparam logic [7:0] V_OPC = 8'h40;
    localparam logic [7:0] V_DIV = 8'h60;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_BYTES (DEPTH),
        .LATENCY     (LAT),
        .VEC_OVF     (V_OVF),
        .VEC_OPC     (V_OPC),
        .VEC_DIV     (V_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_q [$];

    // Reference: memory as a plain byte array, big-endian by index arithmetic.
    function automatic void model_exec(input logic w, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
        int     n;
        longint last;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'({32'h0, a}) + n - 1;
        er   = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
               || (last >= DEPTH);
        rd   = 32'h0;
        if (!er) begin
            for (int i = 0; i < n; i++) begin
                if (w) ref_mem[a + i] = 8'(wd >> (8 * (n - 1 - i)));
                else   rd = (rd << 8) | 32'(ref_mem[a + i]);
            end
        end
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ref_mem[253] = V_OVF;
        ref_mem[254] = V_OPC;
        ref_mem[255] = V_DIV;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        logic [31:0] e_rd;
        logic        e_err;
        int          lat;
        model_exec(w, sz, a, wd, e_rd, e_err);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_idle got=%b want=1", tag, bus.req_ready);
        end
        drive(w, sz, a, wd);
        @(negedge clk);
        idle_inputs();
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            n_checks++;
            if (bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s ready_busy got=%b want=0", tag, bus.req_ready);
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, LAT);
        end
        n_checks++;
        if (bus.rsp_rdata !== e_rd) begin
            n_fail++; $display("FAIL %s rdata got=%h want=%h", tag, bus.rsp_rdata, e_rd);
        end
        n_checks++;
        if (bus.rsp_err !== e_err) begin
            n_fail++; $display("FAIL %s err got=%b want=%b", tag, bus.rsp_err, e_err);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_resp valid=%b ready=%b want 0/1", tag, bus.rsp_valid, bus.req_ready);
        end
        n_checks++;
        if (bus.rsp_rdata !== e_rd || bus.rsp_err !== e_err) begin
            n_fail++;
            $display("FAIL %s hold got=%h/%b want=%h/%b", tag, bus.rsp_rdata, bus.rsp_err, e_rd, e_err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_dut();
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        end
        n_checks++;
        if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic test_vectors();
        do_req(1'b0, 2'd0, 32'd253, 32'h0, "vec_ovf");
        do_req(1'b0, 2'd0, 32'd254, 32'h0, "vec_opc");
        do_req(1'b0, 2'd0, 32'd255, 32'h0, "vec_div");
    endtask

    task automatic prefill();
        for (int a = 0; a < 252; a += 4) begin
            do_req(1'b1, 2'd2, 32'(a), $urandom, "prefill");
        end
        do_req(1'b1, 2'd0, 32'd252, $urandom, "prefill");
    endtask

    task automatic test_byte_order();
        do_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "st_word");
        do_req(1'b0, 2'd0, 32'h10, 32'h0, "ld_byte10");
        do_req(1'b0, 2'd0, 32'h13, 32'h0, "ld_byte13");
        do_req(1'b0, 2'd1, 32'h12, 32'h0, "ld_half12");
        do_req(1'b1, 2'd0, 32'h11, 32'h000000AA, "st_byte11");
        do_req(1'b0, 2'd2, 32'h10, 32'h0, "ld_word10");
        do_req(1'b1, 2'd1, 32'h16, 32'hFFFF1234, "st_half16");
        do_req(1'b0, 2'd2, 32'h14, 32'h0, "ld_word14");
    endtask

    task automatic test_errors();
        do_req(1'b0, 2'd2, 32'h02, 32'h0, "err_word_mis");
        do_req(1'b1, 2'd1, 32'h01, 32'hFFFFFFFF, "err_half_mis");
        do_req(1'b0, 2'd2, 32'hFE, 32'h0, "err_word_fe");
        do_req(1'b1, 2'd3, 32'h00, 32'hFFFFFFFF, "err_rsvd");
        do_req(1'b0, 2'd2, 32'h00, 32'h0, "ld_word0");
        do_req(1'b0, 2'd1, 32'hFF, 32'h0, "err_half_ff");
        do_req(1'b1, 2'd2, 32'hFFFFFFFC, 32'h11111111, "err_nowrap");
        do_req(1'b0, 2'd0, 32'h100, 32'h0, "err_byte_100");
        do_req(1'b0, 2'd2, 32'hFC, 32'h0, "ld_word_fc");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] e_rd;
        logic        e_err;
        int          acc_c [$];
        int          rsp_c [$];
        int          idx;
        logic        accepted;
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h20;
        for (int i = 0; i < 3; i++) begin
            model_exec(1'b0, 2'd2, addrs[i], 32'h0, e_rd, e_err);
            exp_q.push_back(e_rd);
        end
        idx = 0;
        @(negedge clk);
        drive(1'b0, 2'd2, addrs[0], 32'h0);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (bus.req_ready !== ((c % 3) == 0)) begin
                n_fail++; $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, bus.req_ready, (c % 3) == 0);
            end
            if (bus.rsp_valid === 1'b1) begin
                rsp_c.push_back(c);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_rsp cycle=%0d got=%h want=none", c, bus.rsp_rdata);
                end else begin
                    e_rd = exp_q.pop_front();
                    if (bus.rsp_rdata !== e_rd) begin
                        n_fail++; $display("FAIL b2b_rdata cycle=%0d got=%h want=%h", c, bus.rsp_rdata, e_rd);
                    end
                end
            end
            accepted = bus.req_valid && bus.req_ready;
            if (accepted) acc_c.push_back(c);
            @(negedge clk);
            if (accepted) begin
                idx++;
                if (idx < 3) drive(1'b0, 2'd2, addrs[idx], 32'h0);
                else         idle_inputs();
            end
        end
        idle_inputs();
        n_checks++;
        if (acc_c.size() != 3 || rsp_c.size() != 3) begin
            n_fail++; $display("FAIL b2b_counts acc=%0d rsp=%0d want=3/3", acc_c.size(), rsp_c.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_c[i] != 3 * i || rsp_c[i] != 3 * i + 2) begin
                    n_fail++;
                    $display("FAIL b2b_timing idx=%0d acc=%0d rsp=%0d want=%0d/%0d", i, acc_c[i], rsp_c[i], 3 * i, 3 * i + 2);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s rsp_valid cycle=%0d got=1 want=0", tag, c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        drive(1'b1, 2'd2, 32'h20, 32'h12345678);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy ready got=%b want=0", bus.req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        ref_mem[253] = V_OVF; ref_mem[254] = V_OPC; ref_mem[255] = V_DIV;
        n_checks++;
        if (bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_state rdata=%h ready=%b want 0/1", bus.rsp_rdata, bus.req_ready);
        end
        check_quiet("abort_busy");
        do_req(1'b0, 2'd2, 32'h20, 32'h0, "abort_ld20");
        @(negedge clk);
        drive(1'b1, 2'd2, 32'h24, 32'hCAFEF00D);
        reset = 1'b0;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        check_quiet("abort_same_edge");
        do_req(1'b0, 2'd2, 32'h24, 32'h0, "abort_ld24");
        do_req(1'b1, 2'd0, 32'hFD, 32'h5A, "st_vec");
        do_req(1'b0, 2'd0, 32'hFD, 32'h0, "ld_vec_new");
        reset_dut();
        do_req(1'b0, 2'd0, 32'hFD, 32'h0, "ld_vec_restored");
        do_req(1'b0, 2'd2, 32'hFC, 32'h0, "ld_word_fc_after");
    endtask

    task automatic test_random();
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else                           a = 32'($urandom_range(0, 259));
            do_req(w, sz, a, $urandom, "random");
        end
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        idle_inputs();
        test_reset();
        test_vectors();
        prefill();
        test_byte_order();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
